fp_addsub_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. Successor to the combinational half-precision adder.
- Adds generic exponent/mantissa widths, an add/sub mode, a valid/ready handshake with backpressure, correct special-value handling, rounding and exception flags.
- Sits between operand-issue logic and the result writeback in the ALU datapath.

---
 rtl/fp_pkg.sv | 46 ++++
 rtl/fp_lzc.sv | 19 +
 rtl/fp_addsub_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor.
// The unpacked-operand struct and helpers are sized from FP_EXP_W/FP_MAN_W;
// fp_addsub_pipe takes those as its parameter defaults, so change both together.
package fp_pkg;

  localparam int FP_EXP_W = 5;
  localparam int FP_MAN_W = 10;
  localparam int W        = 1 + FP_EXP_W + FP_MAN_W;
  localparam int BIAS     = (1 << (FP_EXP_W - 1)) - 1;
  localparam int EXP_MAX  = (1 << FP_EXP_W) - 1;

  // flags vector layout {invalid, overflow, underflow, inexact}
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;      // denormals report exponent 1
    logic [FP_MAN_W:0]   mant;     // hidden bit included
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
  } fp_unpk_t;

  function automatic logic [W-1:0] fp_qnan();
    return {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
  endfunction

  function automatic fp_unpk_t fp_unpack(input logic [W-1:0] x);
    fp_unpk_t            u;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] f;
    e         = x[W-2:FP_MAN_W];
    f         = x[FP_MAN_W-1:0];
    u.sign    = x[W-1];
    u.exp     = (e == '0) ? FP_EXP_W'(1) : e;
    u.mant    = {(e != '0), f};
    u.is_zero = (e == '0) && (f == '0);
    u.is_inf  = (&e) && (f == '0);
    u.is_nan  = (&e) && (f != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns N for an all-zero input.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int N     = 14,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // highest set bit wins because it is visited last
  always_comb begin
    o_cnt = CNT_W'(N);
    for (int i = 0; i < N; i++)
      if (i_vec[i]) o_cnt = CNT_W'(N - 1 - i);
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage floating-point add/sub with valid/ready and a global stall.
// Optional macro FPADD_RNE_EN: round-to-nearest-even; otherwise truncation
// with overflow saturating to max finite.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   op_i,
  input  logic [EXP_W+MAN_W:0]   opA_i,
  input  logic [EXP_W+MAN_W:0]   opB_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W:0]   res_o,
  output logic [3:0]             flags_o
);

  localparam int STAGES = 3;
  localparam int WD     = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;          // mantissa + guard/round/sticky
  localparam int CW     = EXP_W + 2;          // exponent math headroom
  localparam int LZW    = $clog2(MW + 1);
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] SH_CAP = EXP_W'(MAN_W + 3);

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;

  assign w_adv   = ~r_vld_pipe[STAGES] | ready_i;
  assign ready_o = w_adv;
  assign valid_o = r_vld_pipe[STAGES];

  // ---------------- S1: unpack, specials, swap, align ----------------
  fp_unpk_t         w_ua, w_ub;
  logic             w_a_big, w_big_sign, w_nan, w_spec, w_zsign;
  logic [EXP_W-1:0] w_big_exp, w_sml_exp, w_d;
  logic [MAN_W:0]   w_big_mant, w_sml_mant;
  logic [2*MW-1:0]  w_wide;
  logic [MW-1:0]    w_aligned;
  logic [WD-1:0]    w_spec_res;
  logic [3:0]       w_spec_flg;

  // decode operands (B sign flipped for subtract) and align the smaller one
  always_comb begin
    w_ua       = fp_unpack(opA_i);
    w_ub       = fp_unpack({opB_i[WD-1] ^ op_i, opB_i[WD-2:0]});
    w_a_big    = opA_i[WD-2:0] >= opB_i[WD-2:0];
    w_big_sign = w_a_big ? w_ua.sign : w_ub.sign;
    w_big_exp  = w_a_big ? w_ua.exp  : w_ub.exp;
    w_big_mant = w_a_big ? w_ua.mant : w_ub.mant;
    w_sml_exp  = w_a_big ? w_ub.exp  : w_ua.exp;
    w_sml_mant = w_a_big ? w_ub.mant : w_ua.mant;
    w_d        = w_big_exp - w_sml_exp;
    w_wide     = {w_sml_mant, 3'b000, {MW{1'b0}}} >> w_d;
    if (w_d >= SH_CAP) w_aligned = {{(MW-1){1'b0}}, |w_sml_mant};
    else               w_aligned = {w_wide[2*MW-1:MW+1], w_wide[MW] | (|w_wide[MW-1:0])};
    // only two negative zeros keep a negative zero result
    w_zsign    = w_ua.is_zero & w_ub.is_zero & w_ua.sign & w_ub.sign;
    w_nan      = w_ua.is_nan | w_ub.is_nan |
                 (w_ua.is_inf & w_ub.is_inf & (w_ua.sign ^ w_ub.sign));
    w_spec     = w_nan | w_ua.is_inf | w_ub.is_inf;
    w_spec_flg = '0;
    if (w_nan) begin
      w_spec_res         = fp_qnan();
      w_spec_flg[FLG_NV] = 1'b1;
    end else if (w_ua.is_inf) begin
      w_spec_res = {w_ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      w_spec_res = {w_ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             r1_sign, r1_sub, r1_zsign, r1_spec;
  logic [EXP_W-1:0] r1_exp;
  logic [MW-1:0]    r1_mbig, r1_msml;
  logic [WD-1:0]    r1_spec_res;
  logic [3:0]       r1_spec_flg;

  // stage valid shift register; holds as a whole while stalled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], valid_i};
  end

  // S1 register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r1_sign <= 1'b0; r1_sub <= 1'b0; r1_zsign <= 1'b0; r1_spec <= 1'b0;
      r1_exp  <= '0;   r1_mbig <= '0;  r1_msml <= '0;
      r1_spec_res <= '0; r1_spec_flg <= '0;
    end else if (w_adv) begin
      r1_sign     <= w_big_sign;
      r1_sub      <= w_ua.sign ^ w_ub.sign;
      r1_zsign    <= w_zsign;
      r1_spec     <= w_spec;
      r1_exp      <= w_big_exp;
      r1_mbig     <= {w_big_mant, 3'b000};
      r1_msml     <= w_aligned;
      r1_spec_res <= w_spec_res;
      r1_spec_flg <= w_spec_flg;
    end
  end

  // ---------------- S2: magnitude add/subtract ----------------
  logic [MW:0]      w_sum;
  logic             r2_sign, r2_spec;
  logic [EXP_W-1:0] r2_exp;
  logic [MW:0]      r2_sum;
  logic [WD-1:0]    r2_spec_res;
  logic [3:0]       r2_spec_flg;

  assign w_sum = r1_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                        : ({1'b0, r1_mbig} + {1'b0, r1_msml});

  // S2 register; an exact zero takes the zero-sign rule
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r2_sign <= 1'b0; r2_spec <= 1'b0; r2_exp <= '0; r2_sum <= '0;
      r2_spec_res <= '0; r2_spec_flg <= '0;
    end else if (w_adv) begin
      r2_sign     <= (w_sum == '0) ? r1_zsign : r1_sign;
      r2_spec     <= r1_spec;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
      r2_spec_res <= r1_spec_res;
      r2_spec_flg <= r1_spec_flg;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]   w_lz;
  logic [CW-1:0]    w_maxsh, w_sh, w_en, w_eo;
  logic [MW-1:0]    w_n;
  logic [MAN_W+1:0] w_mr;
  logic [MAN_W-1:0] w_frac;
  logic             w_inc, w_nx, w_ovf;
  logic [WD-1:0]    w_res, r_res;
  logic [3:0]       w_flg, r_flags;

  fp_lzc #(.N(MW), .CNT_W(LZW)) u_lzc (.i_vec(r2_sum[MW-1:0]), .o_cnt(w_lz));

  // left shift stops at exponent 1 so small results stay denormal
  always_comb begin
    w_maxsh = CW'(r2_exp) - CW'(1);
    w_sh    = (CW'(w_lz) > w_maxsh) ? w_maxsh : CW'(w_lz);
    if (r2_sum[MW]) begin
      w_n  = {r2_sum[MW:2], r2_sum[1] | r2_sum[0]};
      w_en = CW'(r2_exp) + CW'(1);
    end else begin
      w_n  = r2_sum[MW-1:0] << w_sh;
      w_en = CW'(r2_exp) - w_sh;
    end
    w_nx = |w_n[2:0];
`ifdef FPADD_RNE_EN
    w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
`else
    w_inc = 1'b0;
`endif
    w_mr = {1'b0, w_n[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    if (w_mr[MAN_W+1]) begin
      w_eo   = w_en + CW'(1);
      w_frac = w_mr[MAN_W:1];
    end else begin
      w_eo   = w_mr[MAN_W] ? w_en : '0;
      w_frac = w_mr[MAN_W-1:0];
    end
    w_ovf = w_eo >= CW'(EMAX);
    w_flg = '0;
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_flg = r2_spec_flg;
    end else if (w_ovf) begin
`ifdef FPADD_RNE_EN
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      w_res = {r2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      w_flg[FLG_OF] = 1'b1;
      w_flg[FLG_NX] = 1'b1;
    end else begin
      w_res = {r2_sign, w_eo[EXP_W-1:0], w_frac};
      w_flg[FLG_NX] = w_nx;
      w_flg[FLG_UF] = w_nx & (w_eo == '0);
    end
  end

  // S3 / output register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_res   <= w_res;
      r_flags <= w_flg;
    end
  end

  assign res_o   = r_res;
  assign flags_o = r_flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed scoreboard bench for fp_addsub_pipe (default half-precision widths).
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rstn_i, valid_i, ready_o, op_i, valid_o, ready_i;
  logic [15:0] opA_i, opB_i, res_o;
  logic [3:0]  flags_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [19:0] exp_q[$];

  fp_addsub_pipe dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .opA_i(opA_i), .opB_i(opB_i), .valid_o(valid_o),
    .ready_i(ready_i), .res_o(res_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // scoreboard: every output transfer is compared with the oldest expectation
  always @(negedge clk) begin
    if (rstn_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed res %h with empty queue", res_o);
      end
      if (exp_q.size() > 0) chk("sb_res_flags", {12'h0, res_o, flags_o}, {12'h0, exp_q.pop_front()});
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // drive one beat; expectation is queued in the cycle it is accepted
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic [15:0] er, input logic [3:0] ef);
    logic ok;
    ok = 1'b0;
    opA_i = a; opB_i = b; op_i = op; valid_i = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (ready_o) begin exp_q.push_back({er, ef}); ok = 1'b1; end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    chk("accept", {31'h0, ok}, 32'h1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stalls;
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_i = 1'b0;
    opA_i = '0; opB_i = '0;
    #12;
    chk("rst_valid_o", {31'h0, valid_o}, 32'h0);
    chk("rst_res_o", {16'h0, res_o}, 32'h0);
    chk("rst_flags_o", {28'h0, flags_o}, 32'h0);
    #11 rstn_i = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, ready_o}, 32'h1);
    sync();

    // latency of a single beat
    send(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
    lat = 0;
    for (int t = 0; t < 20 && !valid_o; t++) begin @(negedge clk); lat++; end
    chk("latency", lat, 3);
    drain();
    sync();

    // directed vectors, streamed back to back
    send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    send(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
`ifdef FPADD_RNE_EN
    send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
    send(16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'b0001);
`else
    send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7BFF, 4'b0101);
    send(16'h3C00, 16'h1001, 1'b0, 16'h3C00, 4'b0001);
`endif
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    send(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000);
    send(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
    send(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000);
    send(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0000);
    send(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000);
    send(16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 4'b0000);
    send(16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000);
    drain();
    sync();

    // backpressure: 5 beats, ready_i low for 6 cycles starting at cycle 2
    stalls = 0;
    fork
      begin
        send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        send(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000);
        send(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
        send(16'h4400, 16'h3C00, 1'b1, 16'h4200, 4'b0000);
        send(16'h3C00, 16'h0000, 1'b0, 16'h3C00, 4'b0000);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (valid_o) begin
            chk("stall_ready_o", {31'h0, ready_o}, 32'h0);
            chk("stall_res_hold", {16'h0, res_o}, 32'h4000);
            stalls++;
          end
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
    join
    chk("stall_cycles", stalls, 5);
    drain();
    sync();

    // asynchronous reset in the middle of a burst
    send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    send(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000);
    send(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
    chk("valid_before_rst", {31'h0, valid_o}, 32'h1);
    #2 rstn_i = 1'b0;
    #1 chk("valid_async_rst", {31'h0, valid_o}, 32'h0);
    chk("res_async_rst", {16'h0, res_o}, 32'h0);
    exp_q.delete();
    @(posedge clk); #3 rstn_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_ghost_after_rst", {31'h0, valid_o}, 32'h0);
    sync();
    send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
